lpf_gain_cal: RTL and testbench

- Clocked calibration controller that drives the gain trim of the dms_lpf1p single-pole filter.
- The filter bench applies a sine and measures the filter's output peak. This block does the reverse: it observes the filter output (real) and closes the loop on gain_trim.
- It runs a 4-bit successive-approximation (SAR) search so the measured output peak magnitude meets VTARGET without exceeding it.
- It sits between the RNM filter and digital control in the CDR loop-filter path.

---
 rtl/lpf_gain_cal_if.sv | 38 +++
 rtl/lpf_gain_cal.sv | 134 +++++++++++++
 tb/tb_lpf_gain_cal.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lpf_gain_cal_if.sv
// lpf_gain_cal_if: control/measurement bundle between the gain calibrator and
// its environment (the digital controller issuing start, and the RNM filter
// output vin fed back in).
//
// Handshake: start is a one-cycle request pulse. It is accepted only on an
// edge where busy=0. busy stays high from that edge until the edge that
// raises done. done (with gain_trim, at_limit and vpk_meas) is a level that
// holds until the next accepted start or rst.
//
// Signals:
//   start     controller -> calibrator  request pulse
//   vin       filter     -> calibrator  filter output voltage (real)
//   gain_trim calibrator -> filter      4-bit gain trim code
//   busy      calibrator -> controller  search in progress
//   done      calibrator -> controller  search finished, result valid
//   at_limit  calibrator -> controller  final code is 4'h0 or 4'hF
//   vpk_meas  calibrator -> controller  last measured peak (real)
//   state     calibrator -> debug       FSM state encoding
interface lpf_gain_cal_if;
  logic       start;
  real        vin;
  logic [3:0] gain_trim;
  logic       busy;
  logic       done;
  logic       at_limit;
  real        vpk_meas;
  logic [2:0] state;

  modport master (
    output start, vin,
    input  gain_trim, busy, done, at_limit, vpk_meas, state
  );

  modport slave (
    input  start, vin,
    output gain_trim, busy, done, at_limit, vpk_meas, state
  );
endinterface

// File: rtl/lpf_gain_cal.sv
// lpf_gain_cal: 4-bit successive-approximation gain calibrator for the
// dms_lpf1p single-pole filter. Each trial code is applied, the filter is
// allowed to settle, and the output peak (vmax-vmin)/2 is then measured over a
// window. A trial bit is cleared if the peak exceeds VTARGET (equality keeps
// it). After four trials the final code is held and done is raised.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any search in progress
//   cal  lpf_gain_cal_if.slave: start, vin in; gain_trim, busy, done,
//        at_limit, vpk_meas, state (debug) out
module lpf_gain_cal #(
  parameter int  SETTLE_CYC = 64,
  parameter int  MEAS_CYC   = 100,
  parameter real VTARGET    = 0.5
) (
  input  logic          clk,
  input  logic          rst,
  lpf_gain_cal_if.slave cal
);

  localparam int CMAX = (SETTLE_CYC > MEAS_CYC) ? SETTLE_CYC : MEAS_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    DECIDE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt;
  logic [1:0]    bit_idx;
  logic [3:0]    gain_q;
  logic          busy_q;
  logic          done_q;
  logic          lim_q;
  real           vpk_q;
  real           vmax;
  real           vmin;

  // Running extremes including the current sample, so the last MEASURE edge
  // can fold its own sample into the result.
  real           nmax;
  real           nmin;
  // Current code after the keep/clear decision for the bit under trial.
  logic [3:0]    kept;

  always_comb begin
    nmax = (cal.vin > vmax) ? cal.vin : vmax;
    nmin = (cal.vin < vmin) ? cal.vin : vmin;
  end

  always_comb begin
    kept = gain_q;
    if (vpk_q > VTARGET) kept[bit_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt     <= '0;
      bit_idx <= 2'd3;
      gain_q  <= 4'hF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lim_q   <= 1'b0;
      vpk_q   <= 0.0;
      vmax    <= 0.0;
      vmin    <= 0.0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (cal.start) begin
            gain_q  <= 4'b1000;
            bit_idx <= 2'd3;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            lim_q   <= 1'b0;
            cnt     <= '0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYC - 1)) begin
            // Window opens on the current sample.
            vmax    <= cal.vin;
            vmin    <= cal.vin;
            cnt     <= '0;
            state_q <= MEASURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEASURE: begin
          vmax <= nmax;
          vmin <= nmin;
          if (cnt == CW'(MEAS_CYC - 1)) begin
            vpk_q   <= (nmax - nmin) / 2.0;
            cnt     <= '0;
            state_q <= DECIDE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DECIDE: begin
          if (bit_idx != 2'd0) begin
            gain_q  <= kept | (4'b0001 << (bit_idx - 2'd1));
            bit_idx <= bit_idx - 2'd1;
            cnt     <= '0;
            state_q <= SETTLE;
          end else begin
            gain_q  <= kept;
            lim_q   <= (kept == 4'h0) || (kept == 4'hF);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cal.gain_trim = gain_q;
  assign cal.busy      = busy_q;
  assign cal.done      = done_q;
  assign cal.at_limit  = lim_q;
  assign cal.vpk_meas  = vpk_q;
  assign cal.state     = state_q;

endmodule

// File: tb/tb_lpf_gain_cal.sv
// tb_lpf_gain_cal: self-checking bench for lpf_gain_cal.
// A behavioural filter model drives vin = A*(code/15)*sin(phase), with the sine
// table pinned to exactly +1/-1 at its extremes so the measured peak equals
// A*code/15. One DUT with VTARGET=0.5 is used; the other target scenarios
// are reached by scaling A instead (target 1.0 at A=1.5 is the same ratio as
// target 0.5 at A=0.75, and so on).
module tb_lpf_gain_cal;

  localparam int  SETTLE_CYC = 64;
  localparam int  MEAS_CYC   = 100;
  localparam real VTARGET    = 0.5;
  localparam int  LATENCY    = 1 + 4 * (SETTLE_CYC + MEAS_CYC + 1);

  logic clk;
  logic rst;
  int   cyc;

  lpf_gain_cal_if ifc ();

  lpf_gain_cal #(
    .SETTLE_CYC (SETTLE_CYC),
    .MEAS_CYC   (MEAS_CYC),
    .VTARGET    (VTARGET)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cal (ifc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen so far; after edge k (1-based) cyc == k.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- filter model ----------------
  real amp;
  bit  const_mode;
  int  phase;
  real tbl[20];

  initial begin
    for (int i = 0; i < 20; i++) tbl[i] = $sin(2.0 * 3.14159265358979 * i / 20.0);
    tbl[5]  = 1.0;
    tbl[15] = -1.0;
  end

  always @(negedge clk) begin
    if (const_mode) ifc.vin = 0.3;
    else ifc.vin = ((amp * real'(ifc.gain_trim)) / 15.0) * tbl[(cyc + phase) % 20];
  end

  // ---------------- scoreboard ----------------
  int  n_checks;
  int  n_pass;
  logic [4:0] exp_q[$];   // {at_limit, code}
  int         exp_cyc_q[$];
  real        exp_vpk_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic chk_real(input string name, input real act, input real req);
    n_checks++;
    if ((act - req) < 1.0e-9 && (req - act) < 1.0e-9) n_pass++;
    else $display("FAIL %s: got %f, required %f (t=%0t)", name, act, req, $time);
  endtask

  // Peak the filter model produces for a given trim code.
  function automatic real peak(input logic [3:0] code);
    if (const_mode) return 0.0;
    return (amp * real'(code)) / 15.0;
  endfunction

  // Plain SAR: try each bit from MSB down, keep it if the resulting peak
  // does not exceed the target.
  task automatic model_push(input int start_edge);
    logic [3:0] code;
    logic [3:0] trial;
    real        last;
    code = 4'h0;
    last = 0.0;
    for (int b = 3; b >= 0; b--) begin
      trial = code | (4'd1 << b);
      last  = peak(trial);
      if (last <= VTARGET) code = trial;
    end
    exp_q.push_back({(code == 4'h0) || (code == 4'hF), code});
    exp_cyc_q.push_back(start_edge + LATENCY - 1);
    exp_vpk_q.push_back(last);
  endtask

  // Monitor: compares every rising done against the oldest expectation.
  logic prev_done;
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (ifc.done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("done_without_start", ifc.done, 0);
        end else begin
          logic [4:0] e;
          int         ec;
          real        ev;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          ev = exp_vpk_q.pop_front();
          chk("final_code", ifc.gain_trim, e[3:0]);
          chk("at_limit", ifc.at_limit, e[4]);
          chk("done_edge", cyc, ec);
          chk("busy_low_at_done", ifc.busy, 0);
          chk_real("vpk_meas", ifc.vpk_meas, ev);
        end
      end
      prev_done = ifc.done;
    end
  end

  // ---------------- driver tasks ----------------
  int start_edge;

  task automatic set_model(input real a, input bit cm);
    amp        = a;
    const_mode = cm;
    phase      = $urandom_range(0, 19);
  endtask

  // Pulse start for one edge; when accepted, queue the expected result and
  // check the immediate response of the start edge.
  task automatic pulse_start(input bit accepted);
    @(negedge clk);
    ifc.start  = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    ifc.start = 1'b0;
    if (accepted) begin
      model_push(start_edge);
      chk("start_code", ifc.gain_trim, 4'h8);
      chk("start_busy", ifc.busy, 1);
      chk("start_done", ifc.done, 0);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!ifc.done && n < 2 * LATENCY) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", ifc.done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_cal(input real a, input bit cm);
    set_model(a, cm);
    pulse_start(1'b1);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] held;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    ifc.start  = 1'b0;
    amp        = 1.0;
    const_mode = 1'b0;
    phase      = 0;
    repeat (3) @(negedge clk);
    chk("rst_code", ifc.gain_trim, 4'hF);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_limit", ifc.at_limit, 0);
    chk("rst_state", ifc.state, 0);
    chk_real("rst_vpk", ifc.vpk_meas, 0.0);
    rst = 1'b0;

    // Nominal: trials 8,4,6,7 -> 7.
    run_cal(1.0, 1'b0);
    // Equality boundary: trial 10 gives exactly the target and is kept.
    run_cal(0.75, 1'b0);
    // Upper limit: every trial under target -> F.
    run_cal(0.25, 1'b0);
    // Lower limit: every trial over target -> 0.
    run_cal(50.0, 1'b0);
    // Constant input: zero peak -> F.
    run_cal(0.0, 1'b1);

    // Reset in the middle of the second iteration's measure window,
    // asserted together with start (reset must win).
    set_model(1.0, 1'b0);
    pulse_start(1'b0);
    while (cyc < start_edge + 2 * (SETTLE_CYC + 1) + MEAS_CYC + 20) @(negedge clk);
    chk("mid_code_iter2", ifc.gain_trim, 4'h4);
    chk("mid_busy", ifc.busy, 1);
    rst       = 1'b1;
    ifc.start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    ifc.start = 1'b0;
    chk("abort_code", ifc.gain_trim, 4'hF);
    chk("abort_busy", ifc.busy, 0);
    chk("abort_done", ifc.done, 0);
    chk("abort_state", ifc.state, 0);
    run_cal(1.0, 1'b0);

    // Start re-pulsed while busy is ignored; completion time unchanged.
    set_model(1.0, 1'b0);
    pulse_start(1'b1);
    repeat ($urandom_range(100, 500)) @(negedge clk);
    held = ifc.gain_trim;
    pulse_start(1'b0);
    chk("busy_restart_code", ifc.gain_trim, held);
    chk("busy_restart_busy", ifc.busy, 1);
    wait_done();

    // Start after done: recalibration from 8, same result.
    pulse_start(1'b1);
    wait_done();

    // Randomized amplitudes and phases.
    for (int t = 0; t < 5; t++) begin
      run_cal(real'($urandom_range(0, 2000)) / 1000.0, 1'b0);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
